// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 shared constants and the D pipeline register layout
package y86_pkg;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [3:0] ICODE_HALT  = 4'h0;
    localparam logic [3:0] ICODE_NOP   = 4'h1;
    localparam logic [3:0] ICODE_RRMOV = 4'h2;
    localparam logic [3:0] ICODE_IRMOV = 4'h3;
    localparam logic [3:0] ICODE_RMMOV = 4'h4;
    localparam logic [3:0] ICODE_MRMOV = 4'h5;
    localparam logic [3:0] ICODE_OP    = 4'h6;
    localparam logic [3:0] ICODE_JXX   = 4'h7;
    localparam logic [3:0] ICODE_CALL  = 4'h8;
    localparam logic [3:0] ICODE_RET   = 4'h9;
    localparam logic [3:0] ICODE_PUSH  = 4'hA;
    localparam logic [3:0] ICODE_POP   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    typedef struct packed {
        logic [1:0]  status;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } dreg_t;

    localparam dreg_t DREG_BUBBLE = '{
        status: STAT_AOK, icode: ICODE_NOP, ifun: 4'h0,
        ra: RNONE, rb: RNONE, valc: 64'd0, valp: 64'd0
    };

endpackage

// File: rtl/decode_pipe_reg.sv
// rtl/decode_pipe_reg.sv - D pipeline register with reset, stall and bubble
module decode_pipe_reg
    import y86_pkg::*;
(
    input  logic  clock,
    input  logic  reset_n,
    input  logic  i_stall,
    input  logic  i_bubble,
    input  dreg_t i_d,
    output dreg_t o_q
);

    dreg_t r_q;

    // Stall outranks bubble so a load-use hold survives a simultaneous squash request.
    always_ff @(posedge clock) begin
        if (!reset_n)
            r_q <= DREG_BUBBLE;
        else if (i_stall)
            r_q <= r_q;
        else if (i_bubble)
            r_q <= DREG_BUBBLE;
        else
            r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - Y86-64 decode stage: D register, operand forwarding, hazard control
module decode_stage
    import y86_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  f_icode,
    input  logic [3:0]  f_ifun,
    input  logic [3:0]  f_ra,
    input  logic [3:0]  f_rb,
    input  logic [63:0] f_valc,
    input  logic [63:0] f_valp,
    input  logic [1:0]  f_status,
    input  logic [63:0] r0,
    input  logic [63:0] r1,
    input  logic [63:0] r2,
    input  logic [63:0] r3,
    input  logic [63:0] r4,
    input  logic [63:0] r5,
    input  logic [63:0] r6,
    input  logic [63:0] r7,
    input  logic [63:0] r8,
    input  logic [63:0] r9,
    input  logic [63:0] r10,
    input  logic [63:0] r11,
    input  logic [63:0] r12,
    input  logic [63:0] r13,
    input  logic [63:0] r14,
    input  logic [3:0]  e_dste,
    input  logic [3:0]  M_dste,
    input  logic [3:0]  M_dstm,
    input  logic [3:0]  W_dste,
    input  logic [3:0]  W_dstm,
    input  logic [63:0] e_vale,
    input  logic [63:0] M_vale,
    input  logic [63:0] m_valm,
    input  logic [63:0] W_vale,
    input  logic [63:0] W_valm,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  M_icode,
    input  logic [3:0]  E_dstm,
    input  logic        e_cnd,
    input  logic [1:0]  m_status,
    input  logic [1:0]  W_status,
    output logic [1:0]  D_status,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_ra,
    output logic [3:0]  D_rb,
    output logic [63:0] D_valc,
    output logic [63:0] D_valp,
    output logic [1:0]  d_status,
    output logic [3:0]  d_icode,
    output logic [3:0]  d_ifun,
    output logic [3:0]  d_srca,
    output logic [3:0]  d_srcb,
    output logic [3:0]  d_dste,
    output logic [3:0]  d_dstm,
    output logic [63:0] d_vala,
    output logic [63:0] d_valb,
    output logic [63:0] d_valc,
    output logic        F_stall,
    output logic        D_stall,
    output logic        D_bubble,
    output logic        E_bubble,
    output logic        M_bubble,
    output logic        W_stall,
    output logic        set_cc
);

    dreg_t       w_f;
    dreg_t       w_d;
    logic [63:0] w_rf [0:15];
    logic [3:0]  w_srca, w_srcb, w_dste, w_dstm;
    logic [63:0] w_vala, w_valb;
    logic        w_load_use, w_ret_in_pipe, w_mispredict;

    assign w_f = '{status: f_status, icode: f_icode, ifun: f_ifun, ra: f_ra,
                   rb: f_rb, valc: f_valc, valp: f_valp};

    decode_pipe_reg u_dreg (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_stall  (w_load_use),
        .i_bubble (D_bubble),
        .i_d      (w_f),
        .o_q      (w_d)
    );

    assign D_status = w_d.status;
    assign D_icode  = w_d.icode;
    assign D_ifun   = w_d.ifun;
    assign D_ra     = w_d.ra;
    assign D_rb     = w_d.rb;
    assign D_valc   = w_d.valc;
    assign D_valp   = w_d.valp;

    // Slot 15 is RNONE, so reading "no register" returns zero without a special case.
    assign w_rf[0]  = r0;   assign w_rf[1]  = r1;   assign w_rf[2]  = r2;
    assign w_rf[3]  = r3;   assign w_rf[4]  = r4;   assign w_rf[5]  = r5;
    assign w_rf[6]  = r6;   assign w_rf[7]  = r7;   assign w_rf[8]  = r8;
    assign w_rf[9]  = r9;   assign w_rf[10] = r10;  assign w_rf[11] = r11;
    assign w_rf[12] = r12;  assign w_rf[13] = r13;  assign w_rf[14] = r14;
    assign w_rf[15] = 64'd0;

    always_comb begin
        w_srca = RNONE;
        w_srcb = RNONE;
        w_dste = RNONE;
        w_dstm = RNONE;
        case (w_d.icode)
            ICODE_RRMOV, ICODE_RMMOV, ICODE_OP, ICODE_PUSH: w_srca = w_d.ra;
            ICODE_POP, ICODE_RET:                          w_srca = RRSP;
            default: ;
        endcase
        case (w_d.icode)
            ICODE_OP, ICODE_RMMOV, ICODE_MRMOV:                 w_srcb = w_d.rb;
            ICODE_PUSH, ICODE_POP, ICODE_CALL, ICODE_RET:       w_srcb = RRSP;
            default: ;
        endcase
        case (w_d.icode)
            ICODE_RRMOV, ICODE_IRMOV, ICODE_OP:                 w_dste = w_d.rb;
            ICODE_PUSH, ICODE_POP, ICODE_CALL, ICODE_RET:       w_dste = RRSP;
            default: ;
        endcase
        case (w_d.icode)
            ICODE_MRMOV, ICODE_POP: w_dstm = w_d.ra;
            default: ;
        endcase
    end

    // Youngest producer wins: execute, then memory (load before ALU), then writeback.
    always_comb begin
        w_vala = w_rf[w_srca];
        if (w_d.icode == ICODE_CALL || w_d.icode == ICODE_JXX) w_vala = w_d.valp;
        else if (w_srca == RNONE)  w_vala = 64'd0;
        else if (w_srca == e_dste) w_vala = e_vale;
        else if (w_srca == M_dstm) w_vala = m_valm;
        else if (w_srca == M_dste) w_vala = M_vale;
        else if (w_srca == W_dstm) w_vala = W_valm;
        else if (w_srca == W_dste) w_vala = W_vale;
    end

    always_comb begin
        w_valb = w_rf[w_srcb];
        if (w_srcb == RNONE)       w_valb = 64'd0;
        else if (w_srcb == e_dste) w_valb = e_vale;
        else if (w_srcb == M_dstm) w_valb = m_valm;
        else if (w_srcb == M_dste) w_valb = M_vale;
        else if (w_srcb == W_dstm) w_valb = W_valm;
        else if (w_srcb == W_dste) w_valb = W_vale;
    end

    assign d_status = w_d.status;
    assign d_icode  = w_d.icode;
    assign d_ifun   = w_d.ifun;
    assign d_valc   = w_d.valc;
    assign d_srca   = w_srca;
    assign d_srcb   = w_srcb;
    assign d_dste   = w_dste;
    assign d_dstm   = w_dstm;
    assign d_vala   = w_vala;
    assign d_valb   = w_valb;

    assign w_load_use = (E_icode == ICODE_MRMOV || E_icode == ICODE_POP) &&
                        (E_dstm != RNONE) &&
                        (E_dstm == w_srca || E_dstm == w_srcb);
    assign w_ret_in_pipe = (w_d.icode == ICODE_RET) || (E_icode == ICODE_RET) ||
                           (M_icode == ICODE_RET);
    assign w_mispredict  = (E_icode == ICODE_JXX) && !e_cnd;

    assign F_stall  = w_load_use | w_ret_in_pipe;
    assign D_stall  = w_load_use;
    assign D_bubble = w_mispredict | (w_ret_in_pipe & ~w_load_use);
    assign E_bubble = w_mispredict | w_load_use;
    assign M_bubble = (m_status != STAT_AOK) | (W_status != STAT_AOK);
    assign W_stall  = (W_status != STAT_AOK);
    assign set_cc   = (E_icode == ICODE_OP) && (m_status == STAT_AOK) &&
                      (W_status == STAT_AOK);

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  f_icode, f_ifun, f_ra, f_rb;
    logic [63:0] f_valc, f_valp;
    logic [1:0]  f_status;
    logic [63:0] r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14;
    logic [3:0]  e_dste, M_dste, M_dstm, W_dste, W_dstm;
    logic [63:0] e_vale, M_vale, m_valm, W_vale, W_valm;
    logic [3:0]  E_icode, M_icode, E_dstm;
    logic        e_cnd;
    logic [1:0]  m_status, W_status;
    logic [1:0]  D_status, d_status;
    logic [3:0]  D_icode, D_ifun, D_ra, D_rb, d_icode, d_ifun;
    logic [3:0]  d_srca, d_srcb, d_dste, d_dstm;
    logic [63:0] D_valc, D_valp, d_vala, d_valb, d_valc;
    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;

    int n_tests = 0;
    int n_fail  = 0;

    decode_stage dut (
        .clock(clock), .reset_n(reset_n),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_ra(f_ra), .f_rb(f_rb),
        .f_valc(f_valc), .f_valp(f_valp), .f_status(f_status),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .r8(r8), .r9(r9), .r10(r10), .r11(r11), .r12(r12), .r13(r13), .r14(r14),
        .e_dste(e_dste), .M_dste(M_dste), .M_dstm(M_dstm), .W_dste(W_dste), .W_dstm(W_dstm),
        .e_vale(e_vale), .M_vale(M_vale), .m_valm(m_valm), .W_vale(W_vale), .W_valm(W_valm),
        .E_icode(E_icode), .M_icode(M_icode), .E_dstm(E_dstm), .e_cnd(e_cnd),
        .m_status(m_status), .W_status(W_status),
        .D_status(D_status), .D_icode(D_icode), .D_ifun(D_ifun), .D_ra(D_ra), .D_rb(D_rb),
        .D_valc(D_valc), .D_valp(D_valp),
        .d_status(d_status), .d_icode(d_icode), .d_ifun(d_ifun),
        .d_srca(d_srca), .d_srcb(d_srcb), .d_dste(d_dste), .d_dstm(d_dstm),
        .d_vala(d_vala), .d_valb(d_valb), .d_valc(d_valc),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] valp);
        f_icode = ic; f_ifun = 4'h0; f_ra = ra; f_rb = rb;
        f_valc = 64'h0; f_valp = valp; f_status = 2'd0;
    endtask

    initial begin
        reset_n = 1'b0;
        fetch(4'h1, 4'hF, 4'hF, 64'h0);
        {r0, r1, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14} = '0;
        r2 = 64'd5; r3 = 64'd7; r4 = 64'd44;
        {e_dste, M_dste, M_dstm, W_dste, W_dstm} = {5{4'hF}};
        {e_vale, M_vale, m_valm, W_vale, W_valm} = '0;
        E_icode = 4'h1; M_icode = 4'h1; E_dstm = 4'hF; e_cnd = 1'b1;
        m_status = 2'd0; W_status = 2'd0;

        tick;
        check("rst_D_icode", D_icode, 64'h1);
        check("rst_D_ra", D_ra, 64'hF);
        check("rst_D_rb", D_rb, 64'hF);
        check("rst_D_status", D_status, 64'h0);
        check("rst_d_srca", d_srca, 64'hF);
        check("rst_d_dste", d_dste, 64'hF);
        check("rst_F_stall", F_stall, 64'h0);

        reset_n = 1'b1;
        fetch(4'h6, 4'h2, 4'h3, 64'h100);
        tick;
        check("op_d_srca", d_srca, 64'h2);
        check("op_d_srcb", d_srcb, 64'h3);
        check("op_d_dste", d_dste, 64'h3);
        check("op_d_dstm", d_dstm, 64'hF);
        check("op_d_vala", d_vala, 64'd5);
        check("op_d_valb", d_valb, 64'd7);

        e_dste = 4'h2; e_vale = 64'd99; W_dste = 4'h2; W_vale = 64'd11; #1;
        check("fwd_e_prio", d_vala, 64'd99);
        e_dste = 4'hF; #1;
        check("fwd_W_vale", d_vala, 64'd11);
        M_dstm = 4'h2; m_valm = 64'd33; #1;
        check("fwd_m_valm", d_vala, 64'd33);
        M_dste = 4'h3; M_vale = 64'd77; #1;
        check("fwd_M_vale_b", d_valb, 64'd77);
        {e_dste, M_dste, M_dstm, W_dste, W_dstm} = {5{4'hF}};

        fetch(4'h6, 4'h4, 4'h3, 64'h102);
        tick;
        E_icode = 4'h5; E_dstm = 4'h4; #1;
        check("lu_F_stall", F_stall, 64'h1);
        check("lu_D_stall", D_stall, 64'h1);
        check("lu_E_bubble", E_bubble, 64'h1);
        check("lu_D_bubble", D_bubble, 64'h0);
        fetch(4'h3, 4'hF, 4'h1, 64'h10C);
        tick;
        check("lu_hold_icode", D_icode, 64'h6);
        check("lu_hold_ra", D_ra, 64'h4);
        E_icode = 4'h6; #1;
        check("lu_not_load", D_stall, 64'h0);

        E_icode = 4'h7; e_cnd = 1'b0; E_dstm = 4'hF; #1;
        check("mp_D_bubble", D_bubble, 64'h1);
        check("mp_E_bubble", E_bubble, 64'h1);
        check("mp_F_stall", F_stall, 64'h0);
        tick;
        check("mp_D_icode", D_icode, 64'h1);
        check("mp_D_ra", D_ra, 64'hF);
        E_icode = 4'h1; e_cnd = 1'b1;

        fetch(4'h9, 4'hF, 4'hF, 64'h200);
        tick;
        check("ret_F_stall", F_stall, 64'h1);
        check("ret_D_bubble", D_bubble, 64'h1);
        check("ret_d_srca", d_srca, 64'h4);
        check("ret_d_vala", d_vala, 64'd44);

        E_icode = 4'h6; W_status = 2'd2; #1;
        check("ws_W_stall", W_stall, 64'h1);
        check("ws_M_bubble", M_bubble, 64'h1);
        check("ws_set_cc", set_cc, 64'h0);
        W_status = 2'd0; #1;
        check("ok_set_cc", set_cc, 64'h1);
        m_status = 2'd3; #1;
        check("ms_M_bubble", M_bubble, 64'h1);
        check("ms_W_stall", W_stall, 64'h0);
        m_status = 2'd0; E_icode = 4'h1;

        fetch(4'h8, 4'hF, 4'hF, 64'h300);
        tick;
        check("ret_bubbled", D_icode, 64'h1);
        tick;
        check("call_d_vala", d_vala, 64'h300);
        check("call_d_srcb", d_srcb, 64'h4);
        check("call_d_valb", d_valb, 64'd44);

        E_icode = 4'hB; E_dstm = 4'h4; #1;
        check("rst_stall_pre", D_stall, 64'h1);
        reset_n = 1'b0;
        tick;
        check("rst_stall_icode", D_icode, 64'h1);
        reset_n = 1'b1; E_icode = 4'h1; E_dstm = 4'hF;

        fetch(4'h5, 4'h7, 4'h2, 64'h40A);
        tick;
        e_dste = 4'hF; e_vale = 64'd123; #1;
        check("mr_d_dstm", d_dstm, 64'h7);
        check("mr_d_srcb", d_srcb, 64'h2);
        check("mr_rnone_vala", d_vala, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
